alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one 8-bit combinational ALU (4-bit op select: add, sub, mul, div, shifts, rotates, logic ops, compares) between NUM_REQ requesters.
- Round-robin arbitration; per-requester valid/ready request channels; one shared, tagged response channel with backpressure.
- Drives the ALU's A/B/select inputs from registered operands and captures its result and carry-out.
- Guards divide-by-zero.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, response tag width; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*NUM_REQ  operand B, packed the same way.
- req_sel  in  4*NUM_REQ  ALU op select; requester i uses bits [4i+3:4i].
- alu_a  out  8  to ALU input A.
- alu_b  out  8  to ALU input B.
- alu_sel  out  4  to ALU op select.
- alu_out  in  8  ALU result.
- alu_carry  in  1  ALU carry-out (9-bit A+B bit 8, independent of select).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  8  result.
- rsp_carry  out  1  captured carry-out.
- rsp_err  out  1  divide-by-zero flag.
- rsp_id  out  ID_W  index of the requester that owns the response.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset value is IDLE.
- IDLE: req_ready is one-hot to the winner of the round-robin search; it is combinational from req_valid and the pointer, and only asserted in IDLE.
- Round-robin search: start at index ptr and take the first i with req_valid[i], going upward mod NUM_REQ.
- On any edge where req_valid[i] & req_ready[i]:
  - capture req_a/req_b/req_sel slice i into op registers and i into id_r;
  - ptr <= (i+1) mod NUM_REQ;
  - go to EXEC.
- No req_valid high: stay in IDLE; ptr unchanged.
- EXEC (exactly 1 cycle): alu_a/alu_b/alu_sel come from op registers. At the edge:
  - rsp_data <= alu_out; rsp_carry <= alu_carry; rsp_err <= 0;
  - override: if sel==4'b0011 and B==0, then rsp_data <= 8'hFF and rsp_err <= 1;
  - go to RESP.
- RESP: rsp_valid=1. rsp_data/carry/err/id are held stable until the rsp_ready edge, then go to IDLE.
- Latency: grant at edge T; rsp_valid is high from cycle T+2. Next grant is possible no earlier than the cycle after the response handshake. Peak throughput is one op per 3 cycles.
- alu_* outputs hold the op registers in all states; they are 0 after reset.
- Requester behaviour is unconstrained: valid may drop before grant with no effect. Operands are sampled only at the grant edge, so later changes do not affect the in-flight op.
- Reset values: req_ready=0 while rst is high; rsp_valid=0; rsp_data=0; rsp_carry=0; rsp_err=0; rsp_id=0; alu_a=0; alu_b=0; alu_sel=0; busy=0; ptr=0.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, and the block returns to IDLE with ptr=0.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that keeps valid high is served within NUM_REQ grants.
- ptr behaviour when NUM_REQ is not a power of two: ptr wraps at NUM_REQ. Tag values >= NUM_REQ never appear.

Test Plan:
- Single op, req0: A=8'd200, B=8'd100, sel=0000 -> req_ready[0] in the valid cycle; rsp_valid 2 cycles later with data=8'd44, carry=1, err=0, id=0.
- All 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; one response every 3 cycles; ids match grant order.
- Divide-by-zero: req2 with A=8'd9, B=0, sel=0011 -> data=8'hFF, err=1, id=2. Then req2 with A=8'd9, B=8'd2, sel=0011 -> data=8'd4, err=0.
- Backpressure: rsp_ready=0 for 5 cycles with req1 and req3 pending -> rsp_valid and data held constant; req_ready stays 0; after rsp_ready goes high, the next grant goes to 3 if the previous grant was 1.
- Operand change after grant: req0 with A=8'h0F, B=8'hF0, sel=1001, then operands change the next cycle -> data=8'hFF (captured values). Compare op sel=1110 with A=5, B=3 -> data=8'd1.
- Async reset asserted during RESP -> rsp_valid, busy and req_ready go 0 immediately; after release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that time-shares one external 8-bit combinational ALU
// between NUM_REQ requesters and returns each result on one tagged response channel.
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0] req_sel,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_sel,
    input  logic [7:0]           alu_out,
    input  logic                 alu_carry,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_err,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    localparam logic [3:0] SEL_DIV = 4'b0011;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [7:0]      op_b_q, op_b_d;
    logic [3:0]      op_sel_q, op_sel_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic            rsp_err_q, rsp_err_d;

    logic [7:0] a_slice   [NUM_REQ];
    logic [7:0] b_slice   [NUM_REQ];
    logic [3:0] sel_slice [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign a_slice[gi]   = req_a[8*gi +: 8];
        assign b_slice[gi]   = req_b[8*gi +: 8];
        assign sel_slice[gi] = req_sel[4*gi +: 4];
    end

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
    logic            hi_found, lo_found, grant_found;
    logic [ID_W-1:0] hi_idx, lo_idx, grant_idx, ptr_next;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(k);
                if (k >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(k);
                end
            end
        end
        grant_found = lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
        ptr_next    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    assign req_ready = (state_q == IDLE && grant_found && !rst)
                     ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sel_d    = op_sel_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d   = a_slice[grant_idx];
                    op_b_d   = b_slice[grant_idx];
                    op_sel_d = sel_slice[grant_idx];
                    id_d     = grant_idx;
                    ptr_d    = ptr_next;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_out;
                rsp_carry_d = alu_carry;
                rsp_err_d   = 1'b0;
                // Divide by zero returns all-ones with the error flag instead of the ALU value.
                if (op_sel_q == SEL_DIV && op_b_q == 8'd0) begin
                    rsp_data_d = 8'hFF;
                    rsp_err_d  = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sel_q    <= '0;
            id_q        <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sel_q    <= op_sel_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign alu_sel   = op_sel_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: a behavioural ALU sits on the alu_* port,
// expected results are hand-computed constants.
module tb_alu_rr_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [8*N-1:0]  req_a;
    logic [8*N-1:0]  req_b;
    logic [4*N-1:0]  req_sel;
    logic [7:0]      alu_a;
    logic [7:0]      alu_b;
    logic [3:0]      alu_sel;
    logic [7:0]      alu_out;
    logic            alu_carry;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_data;
    logic            rsp_carry;
    logic            rsp_err;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // External ALU: 0 add, 1 sub, 2 mul, 3 div, 4 shl, 5 shr, 6 rol, 7 ror,
    // 8 and, 9 or, A xor, B not, C eq, D lt, E gt, F ne.
    logic [8:0]  sum9;
    logic [15:0] rot16;
    always_comb begin
        sum9      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = sum9[8];
        rot16     = '0;
        alu_out   = '0;
        case (alu_sel)
            4'h0: alu_out = sum9[7:0];
            4'h1: alu_out = alu_a - alu_b;
            4'h2: alu_out = alu_a * alu_b;
            4'h3: alu_out = (alu_b == 8'd0) ? 8'd0 : alu_a / alu_b;
            4'h4: alu_out = alu_a << alu_b[2:0];
            4'h5: alu_out = alu_a >> alu_b[2:0];
            4'h6: begin rot16 = {alu_a, alu_a} << alu_b[2:0]; alu_out = rot16[15:8]; end
            4'h7: begin rot16 = {alu_a, alu_a} >> alu_b[2:0]; alu_out = rot16[7:0]; end
            4'h8: alu_out = alu_a & alu_b;
            4'h9: alu_out = alu_a | alu_b;
            4'hA: alu_out = alu_a ^ alu_b;
            4'hB: alu_out = ~alu_a;
            4'hC: alu_out = {7'd0, alu_a == alu_b};
            4'hD: alu_out = {7'd0, alu_a < alu_b};
            4'hE: alu_out = {7'd0, alu_a > alu_b};
            default: alu_out = {7'd0, alu_a != alu_b};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        req_a[8*i +: 8]   = a;
        req_b[8*i +: 8]   = b;
        req_sel[4*i +: 4] = sel;
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] data, input logic carry,
                              input logic err, input logic [IW-1:0] id);
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_data"},  rsp_data,  data);
        check({tag, "_carry"}, rsp_carry, carry);
        check({tag, "_err"},   rsp_err,   err);
        check({tag, "_id"},    rsp_id,    id);
        $display("txn %s: id=%0d data=0x%02h carry=%0b err=%0b", tag, rsp_id, rsp_data, rsp_carry, rsp_err);
    endtask

    // One requester only: grant, EXEC, response check, handshake.
    task automatic run_op(input string tag, input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sel, input logic [7:0] data, input logic carry, input logic err);
        set_req(i, a, b, sel);
        req_valid = N'(1) << i;
        #1;
        check({tag, "_grant"}, req_ready, N'(1) << i);
        tick();
        req_valid = '0;
        tick();
        expect_rsp(tag, data, carry, err, IW'(i));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
    endtask

    int          ord  [6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0]  sums [4] = '{8'd3, 8'd20, 8'd37, 8'd54};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        #2;
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_alu_a",     alu_a,     8'd0);
        check("rst_alu_b",     alu_b,     8'd0);
        check("rst_alu_sel",   alu_sel,   4'd0);
        check("rst_rsp_data",  rsp_data,  8'd0);
        check("rst_rsp_carry", rsp_carry, 1'b0);
        check("rst_rsp_err",   rsp_err,   1'b0);
        check("rst_rsp_id",    rsp_id,    2'd0);
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;

        // All four requesting, consumer always ready: one response per 3 cycles, order 0,1,2,3,0,1.
        for (int i = 0; i < N; i++) set_req(i, 8'(16*i + 1), 8'(i + 2), 4'h0);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            check("rr_grant", req_ready, N'(1) << ord[n]);
            tick();
            check("rr_exec_busy", busy, 1'b1);
            check("rr_exec_noready", req_ready, 4'b0000);
            tick();
            expect_rsp("rr", sums[ord[n]], 1'b0, 1'b0, IW'(ord[n]));
            tick();
        end
        #1;
        check("rr_next_grant", req_ready, 4'b0100);
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        check("rr_idle_noready", req_ready, 4'b0000);

        // Single add with carry, response held one cycle under backpressure.
        set_req(0, 8'd200, 8'd100, 4'h0);
        req_valid = 4'b0001;
        #1;
        check("single_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        check("single_busy",      busy,      1'b1);
        check("single_rsp_valid", rsp_valid, 1'b0);
        check("single_alu_a",     alu_a,     8'd200);
        check("single_alu_b",     alu_b,     8'd100);
        check("single_alu_sel",   alu_sel,   4'h0);
        tick();
        expect_rsp("single", 8'd44, 1'b1, 1'b0, 2'd0);
        tick();
        expect_rsp("single_hold", 8'd44, 1'b1, 1'b0, 2'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("single_done_valid", rsp_valid, 1'b0);
        check("single_done_busy",  busy,      1'b0);

        // Divide by zero, then a legal divide.
        run_op("div0", 2, 8'd9, 8'd0, 4'b0011, 8'hFF, 1'b0, 1'b1);
        run_op("div",  2, 8'd9, 8'd2, 4'b0011, 8'd4,  1'b0, 1'b0);

        // Operands change right after the grant; captured values must be used.
        set_req(0, 8'h0F, 8'hF0, 4'b1001);
        req_valid = 4'b0001;
        #1;
        check("opchg_grant", req_ready, 4'b0001);
        tick();
        set_req(0, 8'h33, 8'h44, 4'b0000);
        #1;
        check("opchg_alu_a",   alu_a,   8'h0F);
        check("opchg_alu_sel", alu_sel, 4'b1001);
        req_valid = '0;
        tick();
        expect_rsp("opchg", 8'hFF, 1'b0, 1'b0, 2'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        run_op("cmp_gt", 0, 8'd5, 8'd3, 4'b1110, 8'd1, 1'b0, 1'b0);

        // Backpressure with req1 and req3 pending; ptr is 1 here.
        set_req(1, 8'h80, 8'h90, 4'h0);
        set_req(3, 8'd7,  8'd8,  4'h1);
        req_valid = 4'b1010;
        #1;
        check("bp_grant1", req_ready, 4'b0010);
        tick();
        tick();
        expect_rsp("bp1", 8'h10, 1'b1, 1'b0, 2'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", rsp_valid, 1'b1);
            check("bp_hold_data",  rsp_data,  8'h10);
            check("bp_hold_id",    rsp_id,    2'd1);
            check("bp_hold_ready", req_ready, 4'b0000);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("bp_grant3", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        tick();
        expect_rsp("bp3", 8'hFF, 1'b0, 1'b0, 2'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Asynchronous reset while in RESP, with ptr advanced past 1.
        req_valid = 4'b1010;
        #1;
        check("ar_grant1", req_ready, 4'b0010);
        tick();
        tick();
        check("ar_in_resp", rsp_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_rsp_valid", rsp_valid, 1'b0);
        check("ar_busy",      busy,      1'b0);
        check("ar_req_ready", req_ready, 4'b0000);
        check("ar_alu_a",     alu_a,     8'd0);
        #1;
        rst = 1'b0;
        #1;
        check("ar_first_grant", req_ready, 4'b0010);
        tick();
        check("ar_regrant_alu_a", alu_a, 8'h80);
        check("ar_regrant_busy",  busy,  1'b1);
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
